decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Pipeline stage directly upstream of the ALU in the core.
- Accepts a fetched 32-bit instruction word plus its PC over a valid/ready handshake and decodes it into the shared `instructions` flag struct (addi, add, beq).
- Extracts register indices and the sign-extended immediate for the execute stage.
- Holds results in a 2-entry elastic buffer (main + skid) so full throughput is kept under downstream backpressure without a combinational ready path.

Parameters:
XLEN, 32, datapath width of PC, instruction and immediate.
REG_W, 5, width of register index fields.

Ports:
clk  in  1  clock; all state updates on rising edge.
rstn  in  1  reset; synchronous, active-high (asserted = 1 despite the name).
flush  in  1  synchronous kill of all buffered instructions (branch redirect).
in_valid  in  1  upstream presents an instruction.
in_ready  out  1  stage can accept this cycle.
in_pc  in  XLEN  PC of presented instruction.
in_instr  in  32  raw instruction word.
out_valid  out  1  decoded instruction available.
out_ready  in  1  execute stage consumes this cycle.
out_pc  out  XLEN  PC of decoded instruction.
out_dec  out  instructions  one-hot decode flags (addi/add/beq); all zero if illegal.
out_rs1  out  REG_W  instr[19:15].
out_rs2  out  REG_W  instr[24:20]; 0 for addi.
out_rd  out  REG_W  instr[11:7]; 0 for beq.
out_imm  out  XLEN  sign-extended immediate.
out_illegal  out  1  word matched no supported encoding.

Behaviour:
- Reset (rstn=1 at a clock edge):
  - out_valid=0, main and skid entries invalid.
  - All out_* data = 0.
  - in_ready forced 0 while rstn=1; in_ready=1 on the first cycle after rstn deasserts.
- Decoding is combinational on in_instr and is registered on accept (in_valid && in_ready).
- Latency: exactly 1 cycle from accept to out_valid with an empty buffer.
- Decode table:
  - addi: opcode 0010011, funct3 000; imm = sext(instr[31:20]).
  - add: opcode 0110011, funct3 000, funct7 0000000; imm = 0.
  - beq: opcode 1100011, funct3 000; imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - Any other word: out_dec all zero, out_illegal=1, imm=0; passes through the pipeline normally (not dropped).
- Handshake:
  - out_* driven from the main entry; out_valid = main valid.
  - in_ready = !skid_valid && !rstn (registered state only; no combinational path from out_ready).
  - Accept while main valid and not draining (out_ready=0 or consumed-and-refill) -> accepted data goes to the skid entry if main stays occupied.
  - On drain (out_valid && out_ready): main <- skid if skid valid, else <- incoming accept, else main invalid.
  - Simultaneous accept and drain with empty skid: main loads the new word and out_valid stays 1 (no bubble).
  - Order strictly preserved; no duplication, no loss.
  - out_* data stable while out_valid && !out_ready.
- Full: main and skid valid -> in_ready=0 next cycle until a drain occurs.
- Flush:
  - At the edge, main and skid are invalidated and any concurrent accept is discarded.
  - out_valid=0 the next cycle; in_ready=1 the next cycle.
- Reset has priority over flush; flush has priority over accept/drain.
- Reset mid-stream: buffered words are discarded, no output afterwards.

Decomposition:
- Shared package (def.sv): `instructions` struct (addi, add, beq flags); opcode constants OP_IMM=7'b0010011, OP=7'b0110011, BRANCH=7'b1100011; funct3/funct7 constants.
- One natural sub-module: decode_comb (purely combinational word -> flags, indices, imm, illegal). decode_stage instantiates it and owns the 2-entry buffer and handshake.

Test Plan:
- addi x1,x2,-3 (0xFFD10093, pc 0x100), out_ready=1 -> next cycle out_valid=1, addi=1, rs1=2, rd=1, imm=0xFFFFFFFD, out_pc=0x100, illegal=0.
- add x3,x1,x2 (0x002081B3) -> add=1, rs1=1, rs2=2, rd=3, imm=0.
- beq x1,x2,-8 (0xFE208CE3) -> beq=1, rs1=1, rs2=2, imm=0xFFFFFFF8.
- 0x00000000, then 0x0000F0B3 (bad funct3) -> each out_illegal=1, out_dec=0, delivered in order.
- Stream 4 words with out_ready=0 for cycles 1-3 -> exactly 2 accepted, in_ready=0 from the cycle after the second accept, outputs held stable. Then out_ready=1 -> all 4 delivered in order, no gaps once flowing.
- Buffer full, then flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed words never appear. Separately, rstn=1 mid-stream -> out_valid=0 and data=0 after the edge.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// Shared decode types: instruction flag struct, opcode/funct constants
// and the buffered entry layout used between decode and execute.
package decode_stage_pkg;

    localparam int XLEN  = 32;
    localparam int REG_W = 5;

    typedef struct packed {
        logic addi;
        logic add;
        logic beq;
    } instructions;

    localparam logic [6:0] OP_IMM  = 7'b0010011;
    localparam logic [6:0] OP      = 7'b0110011;
    localparam logic [6:0] BRANCH  = 7'b1100011;

    localparam logic [2:0] F3_ADDI = 3'b000;
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [6:0] F7_ADD  = 7'b0000000;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        instructions      dec;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic [XLEN-1:0]  imm;
        logic             illegal;
    } dec_ent_t;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch->decode->execute bundle: in_* valid/ready from fetch,
// out_* valid/ready to execute. master = environment, slave = stage.
interface decode_stage_if
    import decode_stage_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int REG_W = 5
) ();

    logic             in_valid;
    logic             in_ready;
    logic [XLEN-1:0]  in_pc;
    logic [31:0]      in_instr;

    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_pc;
    instructions      out_dec;
    logic [REG_W-1:0] out_rs1;
    logic [REG_W-1:0] out_rs2;
    logic [REG_W-1:0] out_rd;
    logic [XLEN-1:0]  out_imm;
    logic             out_illegal;

    modport master (
        output in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_dec,
        input  out_rs1, out_rs2, out_rd, out_imm, out_illegal
    );

    modport slave (
        input  in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_dec,
        output out_rs1, out_rs2, out_rd, out_imm, out_illegal
    );

endinterface

// File: rtl/decode_stage_decode_comb.sv
// Combinational decoder: instr -> flags, reg indices, imm, illegal.
// Ports: instr in; dec, rs1, rs2, rd, imm, illegal out.
module decode_comb
    import decode_stage_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int REG_W = 5
) (
    input  logic [31:0]      instr,
    output instructions      dec,
    output logic [REG_W-1:0] rs1,
    output logic [REG_W-1:0] rs2,
    output logic [REG_W-1:0] rd,
    output logic [XLEN-1:0]  imm,
    output logic             illegal
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       is_addi;
    logic       is_add;
    logic       is_beq;

    assign opc = instr[6:0];
    assign f3  = instr[14:12];
    assign f7  = instr[31:25];

    assign is_addi = (opc == OP_IMM) && (f3 == F3_ADDI);
    assign is_add  = (opc == OP) && (f3 == F3_ADD)
                  && (f7 == F7_ADD);
    assign is_beq  = (opc == BRANCH) && (f3 == F3_BEQ);

    // Illegal words keep their raw register fields; only flags
    // and imm are forced to zero.
    always_comb begin
        dec     = '0;
        illegal = 1'b0;
        imm     = '0;
        rs1     = instr[19:15];
        rs2     = instr[24:20];
        rd      = instr[11:7];
        unique case (1'b1)
            is_addi: begin
                dec.addi = 1'b1;
                rs2      = '0;
                imm      = {{(XLEN-12){instr[31]}},
                            instr[31:20]};
            end
            is_add: begin
                dec.add = 1'b1;
            end
            is_beq: begin
                dec.beq = 1'b1;
                rd      = '0;
                imm     = {{(XLEN-13){instr[31]}},
                           instr[31], instr[7],
                           instr[30:25], instr[11:8],
                           1'b0};
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage with 2-entry (main + skid) elastic output buffer.
// Ports: clk, rstn (sync, active-high), flush, bus (slave).
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int REG_W = 5
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           flush,
    decode_stage_if.slave  bus
);

    dec_ent_t ent_in;
    dec_ent_t main_e;
    dec_ent_t skid_e;
    logic     main_v;
    logic     skid_v;
    logic     acc;
    logic     drain;

    decode_comb #(
        .XLEN  (XLEN),
        .REG_W (REG_W)
    ) u_dec (
        .instr   (bus.in_instr),
        .dec     (ent_in.dec),
        .rs1     (ent_in.rs1),
        .rs2     (ent_in.rs2),
        .rd      (ent_in.rd),
        .imm     (ent_in.imm),
        .illegal (ent_in.illegal)
    );

    assign ent_in.pc = bus.in_pc;

    // Ready depends only on skid occupancy, so out_ready never
    // reaches in_ready combinationally.
    assign bus.in_ready = !skid_v && !rstn;

    assign acc   = bus.in_valid && bus.in_ready;
    assign drain = main_v && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rstn) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            main_e <= '0;
            skid_e <= '0;
        end else if (flush) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (drain) begin
            // skid full implies no accept this cycle
            if (skid_v) begin
                main_e <= skid_e;
                skid_v <= 1'b0;
            end else if (acc) begin
                main_e <= ent_in;
            end else begin
                main_v <= 1'b0;
            end
        end else if (acc) begin
            if (main_v) begin
                skid_e <= ent_in;
                skid_v <= 1'b1;
            end else begin
                main_e <= ent_in;
                main_v <= 1'b1;
            end
        end
    end

    assign bus.out_valid   = main_v;
    assign bus.out_pc      = main_e.pc;
    assign bus.out_dec     = main_e.dec;
    assign bus.out_rs1     = main_e.rs1;
    assign bus.out_rs2     = main_e.rs2;
    assign bus.out_rd      = main_e.rd;
    assign bus.out_imm     = main_e.imm;
    assign bus.out_illegal = main_e.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed words, queue of
// expected records, negedge monitor for transfers and hold stability.
module tb_decode_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [2:0]  dec;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        ill;
    } exp_t;

    logic clk;
    logic rstn;
    logic flush;

    decode_stage_if #(.XLEN(32), .REG_W(5)) bus ();

    decode_stage #(.XLEN(32), .REG_W(5)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .flush (flush),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int pops     = 0;
    exp_t sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, req);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] pc,
                                input logic [2:0] dec,
                                input logic [4:0] rs1,
                                input logic [4:0] rs2,
                                input logic [4:0] rd,
                                input logic [31:0] imm,
                                input logic ill);
        exp_t e;
        e.pc  = pc;
        e.dec = dec;
        e.rs1 = rs1;
        e.rs2 = rs2;
        e.rd  = rd;
        e.imm = imm;
        e.ill = ill;
        return e;
    endfunction

    // Called at a negedge; returns at the negedge after accept.
    task automatic send(input logic [31:0] pc,
                        input logic [31:0] ins, input exp_t e);
        int n;
        bus.in_valid = 1'b1;
        bus.in_pc    = pc;
        bus.in_instr = ins;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            failures++;
            $display("FAIL send_timeout pc=%h got=in_ready0 exp=1",
                     pc);
        end else begin
            sb.push_back(e);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Monitor: transfers and stability while stalled.
    exp_t got;
    exp_t hv;
    exp_t ee;
    logic hold = 1'b0;

    always @(negedge clk) begin
        #2;
        got = mk(bus.out_pc, bus.out_dec, bus.out_rs1,
                 bus.out_rs2, bus.out_rd, bus.out_imm,
                 bus.out_illegal);
        if (!rstn && !flush) begin
            if (hold) begin
                checks++;
                if (!bus.out_valid || got !== hv) begin
                    failures++;
                    $display("FAIL hold got=%h v=%b exp=%h",
                             got, bus.out_valid, hv);
                end
            end
            hold = bus.out_valid && !bus.out_ready;
            hv   = got;
            if (bus.out_valid && bus.out_ready) begin
                pops++;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected got=%h exp=none", got);
                end else begin
                    ee = sb.pop_front();
                    if (got !== ee) begin
                        failures++;
                        $display("FAIL out_rec got=%h exp=%h",
                                 got, ee);
                    end
                end
            end
        end else begin
            hold = 1'b0;
        end
    end

    localparam logic [2:0] D_ADDI = 3'b100;
    localparam logic [2:0] D_ADD  = 3'b010;
    localparam logic [2:0] D_BEQ  = 3'b001;
    localparam logic [2:0] D_NONE = 3'b000;

    int p0;

    initial begin
        rstn          = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_pc     = '0;
        bus.in_instr  = '0;
        bus.out_ready = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_out_pc", bus.out_pc, 0);
        chk("rst_out_imm", bus.out_imm, 0);
        chk("rst_out_dec", 32'(bus.out_dec), 0);

        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        #1;
        chk("ready_after_rst", 32'(bus.in_ready), 1);

        // Single words, consumer always ready.
        @(negedge clk);
        bus.out_ready = 1'b1;
        send(32'h100, 32'hFFD10093,
             mk(32'h100, D_ADDI, 5'd2, 5'd0, 5'd1,
                32'hFFFFFFFD, 1'b0));
        #1;
        chk("lat_out_valid", 32'(bus.out_valid), 1);
        chk("lat_out_pc", bus.out_pc, 32'h100);
        @(negedge clk);
        send(32'h104, 32'h002081B3,
             mk(32'h104, D_ADD, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0));
        send(32'h108, 32'hFE208CE3,
             mk(32'h108, D_BEQ, 5'd1, 5'd2, 5'd0,
                32'hFFFFFFF8, 1'b0));
        send(32'h10C, 32'h00000000,
             mk(32'h10C, D_NONE, 5'd0, 5'd0, 5'd0, 32'h0, 1'b1));
        send(32'h110, 32'h0000F0B3,
             mk(32'h110, D_NONE, 5'd1, 5'd0, 5'd1, 32'h0, 1'b1));
        repeat (3) @(negedge clk);
        #1;
        chk("drained_1", 32'(sb.size()), 0);

        // Backpressure: two accepted, then stalled, then flow.
        @(negedge clk);
        bus.out_ready = 1'b0;
        send(32'h200, 32'h00700293,
             mk(32'h200, D_ADDI, 5'd0, 5'd0, 5'd5, 32'h7, 1'b0));
        send(32'h204, 32'h00528333,
             mk(32'h204, D_ADD, 5'd5, 5'd5, 5'd6, 32'h0, 1'b0));
        #1;
        chk("full_in_ready", 32'(bus.in_ready), 0);
        chk("full_out_pc", bus.out_pc, 32'h200);
        @(negedge clk);
        #1;
        chk("full_in_ready2", 32'(bus.in_ready), 0);
        @(negedge clk);
        bus.out_ready = 1'b1;
        p0 = pops;
        send(32'h208, 32'h00000863,
             mk(32'h208, D_BEQ, 5'd0, 5'd0, 5'd0, 32'h10, 1'b0));
        send(32'h20C, 32'hFFF08393,
             mk(32'h20C, D_ADDI, 5'd1, 5'd0, 5'd7,
                32'hFFFFFFFF, 1'b0));
        #3;
        chk("no_gap_pops", 32'(pops - p0), 4);
        repeat (2) @(negedge clk);
        #1;
        chk("drained_2", 32'(sb.size()), 0);

        // Flush with buffer full and a word presented.
        @(negedge clk);
        bus.out_ready = 1'b0;
        send(32'h300, 32'h00700293,
             mk(32'h300, D_ADDI, 5'd0, 5'd0, 5'd5, 32'h7, 1'b0));
        send(32'h304, 32'h00528333,
             mk(32'h304, D_ADD, 5'd5, 5'd5, 5'd6, 32'h0, 1'b0));
        bus.in_valid = 1'b1;
        bus.in_pc    = 32'h308;
        bus.in_instr = 32'h00000863;
        flush        = 1'b1;
        sb.delete();
        @(negedge clk);
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("flush_out_valid", 32'(bus.out_valid), 0);
        chk("flush_in_ready", 32'(bus.in_ready), 1);
        @(negedge clk);
        bus.out_ready = 1'b1;
        p0 = pops;
        repeat (4) @(negedge clk);
        #3;
        chk("flush_no_out", 32'(pops - p0), 0);
        @(negedge clk);
        send(32'h400, 32'hFFD10093,
             mk(32'h400, D_ADDI, 5'd2, 5'd0, 5'd1,
                32'hFFFFFFFD, 1'b0));
        repeat (2) @(negedge clk);

        // Reset mid-stream.
        bus.out_ready = 1'b0;
        send(32'h500, 32'h002081B3,
             mk(32'h500, D_ADD, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0));
        send(32'h504, 32'hFE208CE3,
             mk(32'h504, D_BEQ, 5'd1, 5'd2, 5'd0,
                32'hFFFFFFF8, 1'b0));
        rstn = 1'b1;
        sb.delete();
        @(negedge clk);
        #1;
        chk("mrst_out_valid", 32'(bus.out_valid), 0);
        chk("mrst_out_pc", bus.out_pc, 0);
        chk("mrst_out_imm", bus.out_imm, 0);
        chk("mrst_out_dec", 32'(bus.out_dec), 0);
        chk("mrst_in_ready", 32'(bus.in_ready), 0);
        @(negedge clk);
        rstn = 1'b0;
        bus.out_ready = 1'b1;
        p0 = pops;
        repeat (3) @(negedge clk);
        #3;
        chk("mrst_no_out", 32'(pops - p0), 0);
        chk("mrst_in_ready2", 32'(bus.in_ready), 1);
        chk("final_empty", 32'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
